qspi_ddr_pad_io: RTL and testbench
==================================

// Module: qspi_ddr_pad_io
// PURPOSE
//   QSPI pad-level PHY between the memhub controller and the external flash pins.
//   - Two DDR output cells (ODDR-equivalent) forward SCK and SS#.
//   - Four bidirectional tri-state pad cells (IOBUF-equivalent) carry IO[3:0].
//   - Portable RTL, no vendor primitives; one clock, synchronous active-low reset.
// PARAMETERS
//   SAME_EDGE  1     1: D1 and D2 both sampled on rising edge; 0: D1 on rising, D2 on falling
//   SCK_INIT   1'b0  SCK value at power-up and during reset_n low
//   SS_INIT    1'b1  SS# value at power-up and during reset_n low
//   IO_W       4     number of bidirectional data pads
// PORTS
//   spiclk   in    1     DDR clock, 133 MHz; both edges used
//   reset_n  in    1     synchronous, active-low, sampled on rising spiclk
//   ce       in    1     clock enable for both DDR cells; 0 holds present outputs
//   sck_d1   in    1     SCK value for high phase
//   sck_d2   in    1     SCK value for low phase
//   sck_r    in    1     synchronous reset of SCK cell (forces 0)
//   ss_d1    in    1     SS# value for high phase
//   ss_d2    in    1     SS# value for low phase
//   ss_s     in    1     synchronous set of SS# cell (forces 1)
//   sck      out   1     to flash CLK pin
//   ssn      out   1     to flash CS# pin
//   io_i     in    IO_W  fabric to pad drive data
//   io_t     in    IO_W  per-bit tristate, 1 = pad released (hi-Z)
//   io_o     out   IO_W  pad to fabric receive data
//   io_pad   inout IO_W  flash IO pins
// BEHAVIOUR
//   DDR cell, sck and ssn identical in structure: rise flop qr, fall flop qf.
//   - Output Q = qr while spiclk is high, qf while spiclk is low; glitch-free mux.
//   - SAME_EDGE=1: rising edge with ce captures qr<=D1 and a pending copy of D2.
//     The following falling edge transfers pending to qf.
//     Both halves therefore come from one rising-edge sample.
//   - SAME_EDGE=0: rising edge captures qr<=D1; falling edge captures qf<=D2 (ce gated).
//   - Priority at each capture edge: reset_n low > sck_r / ss_s > ce > data.
//   - reset_n low at a rising edge loads INIT into qr and pending. qf follows on the next falling edge.
//   - Q = INIT from the first full cycle of reset. Power-up value is also INIT.
//   - sck_r=1 at a rising edge: next high phase and next low phase output 0, in both modes.
//   - ss_s=1: same timing as sck_r, but outputs 1.
//   - ce=0: all flops hold, Q keeps toggling between the held qr and qf.
//   - Latency: D sampled at rising edge k appears on Q from edge k, high phase, to edge k+1.
//   Pad cells, bit-wise and combinational:
//   - io_pad[b] = io_t[b] ? 1'bz : io_i[b].
//   - io_o[b] = io_pad[b], including when this block is driving the pad (loopback).
//   - No reset on the pad path. The controller guarantees io_t=1 during reset.
//   - io_t toggling mid-cycle takes effect immediately; no registering without the macro below.
//   - Concurrent edge event: D inputs changing at a capture edge use the pre-edge value, normal flop semantics.
// CONFIGURATION
//   QSPI_IO_INREG_EN defined:
//   - io_o is registered on the falling edge of spiclk, giving a 0.5-cycle capture stage for the flash read path.
//   - The register is cleared to 0 by reset_n low at a rising edge.
//   QSPI_IO_INREG_EN undefined: io_o is purely combinational from io_pad.
// TESTING
//   - reset_n=0 for 3 cycles -> sck=0, ssn=1, io_pad hi-Z with io_t=4'hF.
//   - ce=1, sck_d1=1, sck_d2=0, SAME_EDGE=1 -> sck mirrors spiclk after 1st rising edge.
//     ss_d1=ss_d2=0 -> ssn constant 0.
//   - sck_r pulsed 1 for one cycle -> sck 0 for exactly one full period, then resumes toggling.
//   - ss_d1=0, ss_d2=1 -> ssn low in high phase, high in low phase.
//     Then ce=0 with changed D -> pattern unchanged.
//   - io_t=4'h0, io_i=4'hA -> io_pad=4'hA, io_o=4'hA.
//     Then io_t=4'hF, bench drives 4'h5 -> io_o=4'h5, no contention.
//   - QSPI_IO_INREG_EN defined, bench drives 4'h3 then 4'hC across falling edges -> io_o updates only at falling edges.
//     SAME_EDGE=0 with D2 changed before a falling edge -> new D2 shown in that low phase.

Source files
------------

// File: rtl/qspi_ddr_pad_io.sv
// QSPI pad PHY: two DDR output cells (SCK, SS#) and IO_W tri-state pad cells.
// Optional macro QSPI_IO_INREG_EN registers io_o on the falling edge of spiclk.
module qspi_ddr_cell #(
  parameter int   SAME_EDGE = 1,
  parameter logic INIT      = 1'b0,
  parameter logic OVR_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic d1,
  input  logic d2,
  input  logic ovr,
  output logic q
);

  logic qr = INIT;
  logic qf = INIT;

  always_ff @(posedge clk) begin
    if (!reset_n)  qr <= INIT;
    else if (ovr)  qr <= OVR_VAL;
    else if (ce)   qr <= d1;
  end

  if (SAME_EDGE != 0) begin : g_same
    logic pend = INIT;

    always_ff @(posedge clk) begin
      if (!reset_n)  pend <= INIT;
      else if (ovr)  pend <= OVR_VAL;
      else if (ce)   pend <= d2;
    end

    always_ff @(negedge clk) qf <= pend;
  end else begin : g_split
    // Reset and override are only sampled on the rising edge; carry them to the falling flop.
    logic hit     = 1'b0;
    logic hit_val = INIT;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        hit     <= 1'b1;
        hit_val <= INIT;
      end else begin
        hit     <= ovr;
        hit_val <= OVR_VAL;
      end
    end

    always_ff @(negedge clk) begin
      if (hit)      qf <= hit_val;
      else if (ce)  qf <= d2;
    end
  end

  // Each flop is stable for the whole phase it is selected in, so the mux cannot glitch.
  assign q = clk ? qr : qf;

endmodule

module qspi_ddr_pad_io #(
  parameter int   SAME_EDGE = 1,
  parameter logic SCK_INIT  = 1'b0,
  parameter logic SS_INIT   = 1'b1,
  parameter int   IO_W      = 4
) (
  input  logic            spiclk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic            sck_d1,
  input  logic            sck_d2,
  input  logic            sck_r,
  input  logic            ss_d1,
  input  logic            ss_d2,
  input  logic            ss_s,
  output logic            sck,
  output logic            ssn,
  input  logic [IO_W-1:0] io_i,
  input  logic [IO_W-1:0] io_t,
  output logic [IO_W-1:0] io_o,
  inout  wire  [IO_W-1:0] io_pad
);

  qspi_ddr_cell #(
    .SAME_EDGE (SAME_EDGE),
    .INIT      (SCK_INIT),
    .OVR_VAL   (1'b0)
  ) u_sck (
    .clk     (spiclk),
    .reset_n (reset_n),
    .ce      (ce),
    .d1      (sck_d1),
    .d2      (sck_d2),
    .ovr     (sck_r),
    .q       (sck)
  );

  qspi_ddr_cell #(
    .SAME_EDGE (SAME_EDGE),
    .INIT      (SS_INIT),
    .OVR_VAL   (1'b1)
  ) u_ss (
    .clk     (spiclk),
    .reset_n (reset_n),
    .ce      (ce),
    .d1      (ss_d1),
    .d2      (ss_d2),
    .ovr     (ss_s),
    .q       (ssn)
  );

  for (genvar b = 0; b < IO_W; b++) begin : g_pad
    assign io_pad[b] = io_t[b] ? 1'bz : io_i[b];
  end

`ifdef QSPI_IO_INREG_EN
  logic            io_clr = 1'b0;
  logic [IO_W-1:0] io_q   = '0;

  always_ff @(posedge spiclk) io_clr <= !reset_n;

  always_ff @(negedge spiclk) io_q <= io_clr ? '0 : io_pad;

  assign io_o = io_clr ? '0 : io_q;
`else
  assign io_o = io_pad;
`endif

endmodule

// File: tb/tb_qspi_ddr_pad_io.sv
// Self-checking bench for qspi_ddr_pad_io: one SAME_EDGE=1 and one SAME_EDGE=0 instance
// checked every phase against a rule-level model, plus literal spot checks.
module tb_qspi_ddr_pad_io;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0, ce = 1'b0;
  logic sck_d1 = 1'b0, sck_d2 = 1'b0, sck_r = 1'b0;
  logic ss_d1 = 1'b0, ss_d2 = 1'b0, ss_s = 1'b0;
  logic [W-1:0] io_i = '0, io_t = '1, tb_val = 4'h5;
  logic [W-1:0] io_o, io_o_b;
  logic [W-1:0] io_i_b = '0, io_t_b = '1;
  logic sck, ssn, sck_b, ssn_b;
  wire [W-1:0] io_pad, io_pad_b;

  for (genvar b = 0; b < W; b++) begin : g_tbdrv
    assign io_pad[b]   = io_t[b]   ? tb_val[b] : 1'bz;
    assign io_pad_b[b] = io_t_b[b] ? tb_val[b] : 1'bz;
  end

  qspi_ddr_pad_io #(.SAME_EDGE(1), .SCK_INIT(1'b0), .SS_INIT(1'b1), .IO_W(W)) u_dut (
    .spiclk(clk), .reset_n(reset_n), .ce(ce),
    .sck_d1(sck_d1), .sck_d2(sck_d2), .sck_r(sck_r),
    .ss_d1(ss_d1), .ss_d2(ss_d2), .ss_s(ss_s),
    .sck(sck), .ssn(ssn),
    .io_i(io_i), .io_t(io_t), .io_o(io_o), .io_pad(io_pad)
  );

  qspi_ddr_pad_io #(.SAME_EDGE(0), .SCK_INIT(1'b0), .SS_INIT(1'b1), .IO_W(W)) u_dut_b (
    .spiclk(clk), .reset_n(reset_n), .ce(ce),
    .sck_d1(sck_d1), .sck_d2(sck_d2), .sck_r(sck_r),
    .ss_d1(ss_d1), .ss_d2(ss_d2), .ss_s(ss_s),
    .sck(sck_b), .ssn(ssn_b),
    .io_i(io_i_b), .io_t(io_t_b), .io_o(io_o_b), .io_pad(io_pad_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each output must show in the coming high / low phase.
  logic e_sck_hi = 1'b0, e_sck_lo = 1'b0, e_sck_lo2 = 1'b0;
  logic e_ss_hi  = 1'b1, e_ss_lo  = 1'b1, e_ss_lo2  = 1'b1;
  logic saw_rst = 1'b0, saw_sckr = 1'b0, saw_sss = 1'b0;

  always @(posedge clk) begin
    saw_rst  = !reset_n;
    saw_sckr = sck_r;
    saw_sss  = ss_s;
    if (!reset_n) begin
      e_sck_hi = 1'b0; e_sck_lo = 1'b0;
      e_ss_hi  = 1'b1; e_ss_lo  = 1'b1;
    end else begin
      if (sck_r)   begin e_sck_hi = 1'b0;   e_sck_lo = 1'b0;   end
      else if (ce) begin e_sck_hi = sck_d1; e_sck_lo = sck_d2; end
      if (ss_s)    begin e_ss_hi = 1'b1;    e_ss_lo = 1'b1;    end
      else if (ce) begin e_ss_hi = ss_d1;   e_ss_lo = ss_d2;   end
    end
  end

  always @(negedge clk) begin
    if (saw_rst) begin
      e_sck_lo2 = 1'b0; e_ss_lo2 = 1'b1;
    end else begin
      if (saw_sckr)  e_sck_lo2 = 1'b0;
      else if (ce)   e_sck_lo2 = sck_d2;
      if (saw_sss)   e_ss_lo2 = 1'b1;
      else if (ce)   e_ss_lo2 = ss_d2;
    end
  end

  function automatic logic [W-1:0] pad_val(input logic [W-1:0] t, input logic [W-1:0] i);
    return (t & tb_val) | (~t & i);
  endfunction

`ifdef QSPI_IO_INREG_EN
  logic e_clr = 1'b0, e_clr_b = 1'b0;
  logic [W-1:0] e_q = '0, e_q_b = '0;
  always @(posedge clk) begin e_clr = !reset_n; e_clr_b = !reset_n; end
  always @(negedge clk) begin
    e_q   = e_clr   ? '0 : pad_val(io_t, io_i);
    e_q_b = e_clr_b ? '0 : pad_val(io_t_b, io_i_b);
  end
  function automatic logic [W-1:0] exp_io();   return e_clr   ? '0 : e_q;   endfunction
  function automatic logic [W-1:0] exp_io_b(); return e_clr_b ? '0 : e_q_b; endfunction
`else
  function automatic logic [W-1:0] exp_io();   return pad_val(io_t, io_i);     endfunction
  function automatic logic [W-1:0] exp_io_b(); return pad_val(io_t_b, io_i_b); endfunction
`endif

  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk); #1;
      chk("sck_hi",   32'(sck),   32'(e_sck_hi));
      chk("ssn_hi",   32'(ssn),   32'(e_ss_hi));
      chk("sck_b_hi", 32'(sck_b), 32'(e_sck_hi));
      chk("ssn_b_hi", 32'(ssn_b), 32'(e_ss_hi));
      chk("io_o_hi",  32'(io_o),  32'(exp_io()));
      chk("io_o_b_hi", 32'(io_o_b), 32'(exp_io_b()));
      @(negedge clk); #1;
      chk("sck_lo",   32'(sck),   32'(e_sck_lo));
      chk("ssn_lo",   32'(ssn),   32'(e_ss_lo));
      chk("sck_b_lo", 32'(sck_b), 32'(e_sck_lo2));
      chk("ssn_b_lo", 32'(ssn_b), 32'(e_ss_lo2));
      chk("io_o_lo",  32'(io_o),  32'(exp_io()));
      chk("io_o_b_lo", 32'(io_o_b), 32'(exp_io_b()));
    end
  end

  task automatic hi(); @(posedge clk); #1; endtask
  task automatic lo(); @(negedge clk); #1; endtask

  // {ce, sck_r, ss_s, sck_d1, sck_d2, ss_d1, ss_d2}, io_t, io_i, tb_val
  typedef struct { logic [6:0] c; logic [W-1:0] t, i, v; } vec_t;
  vec_t vecs[6] = '{
    '{7'b1000110, 4'h0, 4'h6, 4'h0},
    '{7'b1001001, 4'hF, 4'h0, 4'h9},
    '{7'b0001111, 4'h5, 4'hA, 4'h5},
    '{7'b1101011, 4'hA, 4'h5, 4'hA},
    '{7'b1011100, 4'h3, 4'hC, 4'h2},
    '{7'b1000000, 4'hF, 4'h1, 4'hE}
  };

  initial begin
    // Reset for three rising edges, pads released, bench drives 4'h5.
    hi(); hi(); hi();
    chk("rst_sck", 32'(sck), 32'h0);
    chk("rst_ssn", 32'(ssn), 32'h1);
`ifndef QSPI_IO_INREG_EN
    chk("rst_io", 32'(io_o), 32'h5);
`endif
    lo();
    chk("rst_sck_lo", 32'(sck_b), 32'h0);
    chk("rst_ssn_lo", 32'(ssn_b), 32'h1);

    reset_n = 1'b1; ce = 1'b1; sck_d1 = 1'b1; sck_d2 = 1'b0; ss_d1 = 1'b0; ss_d2 = 1'b0;
    hi();
    chk("mirror_hi", 32'(sck), 32'h1);
    chk("ssn_low_hi", 32'(ssn), 32'h0);
    lo();
    chk("mirror_lo", 32'(sck), 32'h0);
    chk("ssn_low_lo", 32'(ssn), 32'h0);
    hi(); lo();

    sck_r = 1'b1;
    hi();
    chk("sckr_hi", 32'(sck), 32'h0);
    chk("sckr_b_hi", 32'(sck_b), 32'h0);
    #1 sck_r = 1'b0;
    lo();
    chk("sckr_lo", 32'(sck), 32'h0);
    chk("sckr_b_lo", 32'(sck_b), 32'h0);
    hi();
    chk("sckr_resume", 32'(sck), 32'h1);
    lo();

    ss_d1 = 1'b0; ss_d2 = 1'b1;
    hi();
    chk("ss_pat_hi", 32'(ssn), 32'h0);
    lo();
    chk("ss_pat_lo", 32'(ssn), 32'h1);
    chk("ss_pat_b_lo", 32'(ssn_b), 32'h1);

    ce = 1'b0; sck_d1 = 1'b0; sck_d2 = 1'b1; ss_d1 = 1'b1; ss_d2 = 1'b0;
    for (int n = 0; n < 2; n++) begin
      hi();
      chk("hold_sck_hi", 32'(sck), 32'h1);
      chk("hold_ssn_hi", 32'(ssn), 32'h0);
      lo();
      chk("hold_sck_lo", 32'(sck_b), 32'h0);
      chk("hold_ssn_lo", 32'(ssn_b), 32'h1);
    end

    ce = 1'b1; sck_d1 = 1'b1; sck_d2 = 1'b0; ss_d1 = 1'b0; ss_d2 = 1'b1; ss_s = 1'b1;
    hi();
    chk("sss_hi", 32'(ssn), 32'h1);
    #1 ss_s = 1'b0;
    lo();
    chk("sss_lo", 32'(ssn), 32'h1);
    chk("sss_b_lo", 32'(ssn_b), 32'h1);
    hi();
    chk("sss_resume", 32'(ssn), 32'h0);

    // D2 changed after the rising edge: only the split-edge cell shows it.
    #1 sck_d2 = 1'b1;
    lo();
    chk("d2_same", 32'(sck), 32'h0);
    chk("d2_split", 32'(sck_b), 32'h1);
    sck_d2 = 1'b0;

    io_t = 4'h0; io_i = 4'hA;
    hi();
`ifndef QSPI_IO_INREG_EN
    chk("io_drive", 32'(io_o), 32'hA);
`endif
    lo();
    io_t = 4'hF; tb_val = 4'h5;
    hi();
`ifndef QSPI_IO_INREG_EN
    chk("io_release", 32'(io_o), 32'h5);
`endif
    lo();
    io_t = 4'hC; io_i = 4'h3; tb_val = 4'hA;
    hi();
`ifndef QSPI_IO_INREG_EN
    chk("io_mixed", 32'(io_o), 32'hB);
`endif
    lo();

    reset_n = 1'b0;
    hi();
    chk("rst2_sck", 32'(sck), 32'h0);
    chk("rst2_ssn", 32'(ssn), 32'h1);
    lo();
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      {ce, sck_r, ss_s, sck_d1, sck_d2, ss_d1, ss_d2} = vecs[k].c;
      io_t = vecs[k].t; io_i = vecs[k].i; tb_val = vecs[k].v;
      hi(); lo();
    end
    hi(); lo();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
